ode_msd_engine: RTL and testbench



---
 rtl/ode_pkg.sv | 33 +++
 rtl/ode_narrow.sv | 40 ++++
 rtl/ode_msd_engine.sv | 128 ++++++++++++
 tb/tb_ode_msd_engine.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ode_pkg.sv
// ode_pkg: shared constants and helpers for the mass-spring-damper ODE engine.
//   - DEF_W / DEF_FRAC : default data width and fractional bits (Q3.14).
//   - ACC_W            : width of the wide intermediate arithmetic. It must be at
//                        least 2*W+1 bits, so W may be at most 31.
//   - IDLE..UPD_X      : FSM state encodings.
//   - SAT_MAX/SAT_MIN  : clamp limits for a DEF_W-bit signed value.
//   - shift_add        : base + (delta >>> sh), evaluated at ACC_W bits.
package ode_pkg;

  localparam int DEF_W    = 18;
  localparam int DEF_FRAC = 14;
  localparam int ACC_W    = 64;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] MUL   = 3'd1;
  localparam logic [2:0] ACC   = 3'd2;
  localparam logic [2:0] UPD_V = 3'd3;
  localparam logic [2:0] UPD_X = 3'd4;

  localparam logic signed [DEF_W-1:0] SAT_MAX = {1'b0, {(DEF_W-1){1'b1}}};
  localparam logic signed [DEF_W-1:0] SAT_MIN = {1'b1, {(DEF_W-1){1'b0}}};

  // The operands are sign-extended to ACC_W before this is called. The shift
  // therefore acts on the true value, and narrowing happens later in one place.
  function automatic logic signed [ACC_W-1:0] shift_add(
    input logic signed [ACC_W-1:0] base,
    input logic signed [ACC_W-1:0] delta,
    input int                      sh
  );
    return base + (delta >>> sh);
  endfunction

endpackage

// File: rtl/ode_narrow.sv
// ode_narrow: narrows a wide signed value to OUT_W bits.
//   Config macro ODE_SAT_EN: when it is defined, the result clamps to
//   [-2^(OUT_W-1), 2^(OUT_W-1)-1]. When it is undefined, the upper bits are
//   dropped, so the value wraps in two's complement.
// Ports:
//   din  : input  signed IN_W  - wide value
//   dout : output signed OUT_W - narrowed value
module ode_narrow
  import ode_pkg::*;
#(
  parameter int IN_W  = ACC_W,
  parameter int OUT_W = DEF_W
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

`ifdef ODE_SAT_EN
  // The limits are built at the full input width, so the signed compares
  // operate on the whole value.
  localparam logic signed [IN_W-1:0] HI = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] LO = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    dout = din[OUT_W-1:0];
    if (din > HI) begin
      dout = HI[OUT_W-1:0];
    end else if (din < LO) begin
      dout = LO[OUT_W-1:0];
    end
  end
`else
  logic unused_hi;

  assign dout      = din[OUT_W-1:0];
  // The discarded upper bits are intentionally unused when wrapping.
  assign unused_hi = ^din[IN_W-1:OUT_W];
`endif

endmodule

// File: rtl/ode_msd_engine.sv
// ode_msd_engine: integrates x'' = -k*x - b*v with semi-implicit Euler
// (dt = 2^-DT_SHIFT) in signed Q(W-FRAC).FRAC fixed point. It takes its
// operands from the Nios II PIO exports.
//   Config macro ODE_SAT_EN: every W-bit narrowing saturates when it is
//   defined and wraps when it is undefined.
// Ports:
//   clk_clk       : system clock
//   reset_reset_n : asynchronous active-low reset
//   rst_i         : synchronous soft reset / load of x_init, v_init
//   clk_en_i      : run enable
//   x_init/v_init : initial position / velocity
//   k_coef/b_coef : spring / damping coefficients
//   x_out/v_out   : registered state
//   sample_valid  : one-cycle pulse, aligned with the updated x_out/v_out
//   step_cnt      : steps completed since load (wraps)
//   busy          : high while a step is in flight
module ode_msd_engine
  import ode_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int FRAC     = DEF_FRAC,
  parameter int DT_SHIFT = 6,
  parameter int STEP_W   = 16
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                rst_i,
  input  logic                clk_en_i,
  input  logic signed [W-1:0] x_init,
  input  logic signed [W-1:0] v_init,
  input  logic signed [W-1:0] k_coef,
  input  logic signed [W-1:0] b_coef,
  output logic signed [W-1:0] x_out,
  output logic signed [W-1:0] v_out,
  output logic                sample_valid,
  output logic [STEP_W-1:0]   step_cnt,
  output logic                busy
);

  logic [2:0]              state;
  logic signed [W-1:0]     x_reg;
  logic signed [W-1:0]     v_reg;
  logic signed [W-1:0]     a_reg;
  logic signed [2*W-1:0]   px;
  logic signed [2*W-1:0]   pv;

  logic signed [ACC_W-1:0] s_wide;
  logic signed [ACC_W-1:0] a_wide;
  logic signed [ACC_W-1:0] v_sum;
  logic signed [ACC_W-1:0] x_sum;
  logic signed [W-1:0]     a_nar;
  logic signed [W-1:0]     v_nar;
  logic signed [W-1:0]     x_nar;

  // The acceleration is -(px + pv) scaled back from Q(2*FRAC) to Q(FRAC).
  // The negation is applied after the floor shift.
  assign s_wide = ACC_W'(px) + ACC_W'(pv);
  assign a_wide = -shift_add('0, s_wide, FRAC);

  // v_sum uses the registered acceleration. x_sum uses v_reg after UPD_V has
  // written it, which makes the integration semi-implicit.
  assign v_sum = shift_add(ACC_W'(v_reg), ACC_W'(a_reg), DT_SHIFT);
  assign x_sum = shift_add(ACC_W'(x_reg), ACC_W'(v_reg), DT_SHIFT);

  ode_narrow #(.IN_W(ACC_W), .OUT_W(W)) u_narrow_a (.din(a_wide), .dout(a_nar));
  ode_narrow #(.IN_W(ACC_W), .OUT_W(W)) u_narrow_v (.din(v_sum),  .dout(v_nar));
  ode_narrow #(.IN_W(ACC_W), .OUT_W(W)) u_narrow_x (.din(x_sum),  .dout(x_nar));

  // A soft reset overrides every state and aborts any step in flight. While
  // rst_i stays high, x/v keep reloading from the PIO values, so the Nios
  // can write them in any order before it releases rst_i.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state        <= IDLE;
      x_reg        <= '0;
      v_reg        <= '0;
      a_reg        <= '0;
      px           <= '0;
      pv           <= '0;
      step_cnt     <= '0;
      sample_valid <= 1'b0;
    end else if (rst_i) begin
      state        <= IDLE;
      x_reg        <= x_init;
      v_reg        <= v_init;
      step_cnt     <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (clk_en_i) begin
            state <= MUL;
          end
        end
        MUL: begin
          // The coefficients are sampled only here. A coefficient change made
          // later in a step therefore waits for the next step.
          px    <= (2*W)'(k_coef) * (2*W)'(x_reg);
          pv    <= (2*W)'(b_coef) * (2*W)'(v_reg);
          state <= ACC;
        end
        ACC: begin
          a_reg <= a_nar;
          state <= UPD_V;
        end
        UPD_V: begin
          v_reg <= v_nar;
          state <= UPD_X;
        end
        UPD_X: begin
          x_reg        <= x_nar;
          step_cnt     <= step_cnt + STEP_W'(1);
          sample_valid <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign x_out = x_reg;
  assign v_out = v_reg;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_ode_msd_engine.sv
// tb_ode_msd_engine: scoreboard bench for ode_msd_engine.
//   dut  : default parameters (DT_SHIFT=6, STEP_W=16)
//   dut2 : DT_SHIFT=0, STEP_W=4 (used for the saturation/wrap and counter-wrap cases)
// Both instances share the same stimulus. Honours ODE_SAT_EN in its reference model.
module tb_ode_msd_engine;

  logic                clk;
  logic                rst_n;
  logic                rst_i;
  logic                clk_en;
  logic signed [17:0]  x_init;
  logic signed [17:0]  v_init;
  logic signed [17:0]  k_coef;
  logic signed [17:0]  b_coef;

  logic signed [17:0]  x_out;
  logic signed [17:0]  v_out;
  logic                sample_valid;
  logic [15:0]         step_cnt;
  logic                busy;

  logic signed [17:0]  x2_out;
  logic signed [17:0]  v2_out;
  logic                sample2_valid;
  logic [3:0]          step2_cnt;
  logic                busy2;

  typedef struct {
    longint x;
    longint v;
    int     step;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;

  ode_msd_engine dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .rst_i         (rst_i),
    .clk_en_i      (clk_en),
    .x_init        (x_init),
    .v_init        (v_init),
    .k_coef        (k_coef),
    .b_coef        (b_coef),
    .x_out         (x_out),
    .v_out         (v_out),
    .sample_valid  (sample_valid),
    .step_cnt      (step_cnt),
    .busy          (busy)
  );

  ode_msd_engine #(.DT_SHIFT(0), .STEP_W(4)) dut2 (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .rst_i         (rst_i),
    .clk_en_i      (clk_en),
    .x_init        (x_init),
    .v_init        (v_init),
    .k_coef        (k_coef),
    .b_coef        (b_coef),
    .x_out         (x2_out),
    .v_out         (v2_out),
    .sample_valid  (sample2_valid),
    .step_cnt      (step2_cnt),
    .busy          (busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model of one 18-bit step.
  function automatic longint narrow18(input longint val);
`ifdef ODE_SAT_EN
    if (val > 131071) return 131071;
    if (val < -131072) return -131072;
    return val;
`else
    longint r;
    r = val & 64'h3FFFF;
    if (r > 131071) r = r - 262144;
    return r;
`endif
  endfunction

  function automatic void model_step(input longint x, input longint v, input longint k,
                                     input longint b, input int dts,
                                     output longint xn, output longint vn);
    longint s;
    longint a;
    s  = k * x + b * v;
    a  = narrow18(-(s >>> 14));
    vn = narrow18(v + (a >>> dts));
    xn = narrow18(x + (vn >>> dts));
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input longint x, input longint v, input longint k, input longint b);
    clk_en = 1'b0;
    rst_i  = 1'b1;
    x_init = 18'(x);
    v_init = 18'(v);
    k_coef = 18'(k);
    b_coef = 18'(b);
    tick;
    rst_i  = 1'b0;
  endtask

  task automatic test_reset;
    rst_i  = 1'b0;
    clk_en = 1'b0;
    x_init = 18'sd16384;
    v_init = -18'sd100;
    k_coef = '0;
    b_coef = '0;
    rst_n  = 1'b1;
    #2 rst_n = 1'b0;
    tick;
    n_cmp++;
    if (x_out !== 18'sd0 || v_out !== 18'sd0) begin
      n_bad++;
      $display("[TB] FAIL async_reset_xv: got x=%0d v=%0d, required 0/0", x_out, v_out);
    end
    n_cmp++;
    if (step_cnt !== 16'd0 || busy !== 1'b0 || sample_valid !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL async_reset_ctl: got step=%0d busy=%b sv=%b, required 0/0/0",
               step_cnt, busy, sample_valid);
    end
    rst_n = 1'b1;
    rst_i = 1'b1;
    tick;
    n_cmp++;
    if (x_out !== 18'sd16384 || v_out !== -18'sd100) begin
      n_bad++;
      $display("[TB] FAIL load_xv: got x=%0d v=%0d, required 16384/-100", x_out, v_out);
    end
    n_cmp++;
    if (step_cnt !== 16'd0 || busy !== 1'b0 || sample_valid !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL load_ctl: got step=%0d busy=%b sv=%b, required 0/0/0",
               step_cnt, busy, sample_valid);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_single_step;
    exp_t   e;
    longint ex;
    longint ev;
    int     seen;
    load(16384, 0, 16384, 0);
    model_step(16384, 0, 16384, 0, 6, ex, ev);
    exp_q.push_back('{ex, ev, 1});
    clk_en = 1'b1;
    tick;
    clk_en = 1'b0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick;
      if (sample_valid === 1'b1) begin
        seen++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("[TB] FAIL single_extra: got unexpected sample, required none");
        end else begin
          e = exp_q.pop_front();
          if (x_out !== 18'(e.x) || v_out !== 18'(e.v) || step_cnt !== 16'(e.step)) begin
            n_bad++;
            $display("[TB] FAIL single_sample: got x=%0d v=%0d step=%0d, required %0d/%0d/%0d",
                     x_out, v_out, step_cnt, e.x, e.v, e.step);
          end
        end
      end
    end
    n_cmp++;
    if (seen !== 1 || busy !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL single_count: got samples=%0d busy=%b, required 1/0", seen, busy);
    end
    n_cmp++;
    if (x_out !== 18'sd16380 || v_out !== -18'sd256 || step_cnt !== 16'd1) begin
      n_bad++;
      $display("[TB] FAIL single_values: got x=%0d v=%0d step=%0d, required 16380/-256/1",
               x_out, v_out, step_cnt);
    end
    exp_q.delete();
  endtask

  task automatic test_free_run;
    exp_t   e;
    longint mx;
    longint mv;
    int     seen;
    int     last;
    load(10000, -2000, 3000, 500);
    mx = 10000;
    mv = -2000;
    for (int i = 1; i <= 10; i++) begin
      model_step(mx, mv, 3000, 500, 6, mx, mv);
      exp_q.push_back('{mx, mv, i});
    end
    seen = 0;
    last = -1;
    clk_en = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick;
      if (c == 50) clk_en = 1'b0;
      if (sample_valid === 1'b1) begin
        seen++;
        if (last >= 0) begin
          n_cmp++;
          if (c - last != 5) begin
            n_bad++;
            $display("[TB] FAIL free_period: got %0d cycles, required 5", c - last);
          end
        end
        last = c;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("[TB] FAIL free_extra: got unexpected sample at cycle %0d, required none", c);
        end else begin
          e = exp_q.pop_front();
          if (x_out !== 18'(e.x) || v_out !== 18'(e.v) || step_cnt !== 16'(e.step)) begin
            n_bad++;
            $display("[TB] FAIL free_sample: got x=%0d v=%0d step=%0d, required %0d/%0d/%0d",
                     x_out, v_out, step_cnt, e.x, e.v, e.step);
          end
        end
      end
    end
    n_cmp++;
    if (seen !== 10 || step_cnt !== 16'd10 || busy !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL free_total: got samples=%0d step=%0d busy=%b, required 10/10/0",
               seen, step_cnt, busy);
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back;
    exp_t   e;
    longint mx;
    longint mv;
    int     seen;
    load(8000, 1000, 2000, 100);
    model_step(8000, 1000, 2000, 100, 6, mx, mv);
    exp_q.push_back('{mx, mv, 1});
    model_step(mx, mv, -5000, 100, 6, mx, mv);
    exp_q.push_back('{mx, mv, 2});
    seen = 0;
    clk_en = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick;
      // k changes after the first step has sampled it; only step two sees it.
      if (c == 2) k_coef = -18'sd5000;
      if (c == 10) clk_en = 1'b0;
      if (sample_valid === 1'b1) begin
        seen++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("[TB] FAIL b2b_extra: got unexpected sample, required none");
        end else begin
          e = exp_q.pop_front();
          if (x_out !== 18'(e.x) || v_out !== 18'(e.v) || step_cnt !== 16'(e.step)) begin
            n_bad++;
            $display("[TB] FAIL b2b_sample: got x=%0d v=%0d step=%0d, required %0d/%0d/%0d",
                     x_out, v_out, step_cnt, e.x, e.v, e.step);
          end
        end
      end
    end
    n_cmp++;
    if (seen !== 2) begin
      n_bad++;
      $display("[TB] FAIL b2b_count: got %0d samples, required 2", seen);
    end
    exp_q.delete();
  endtask

  task automatic test_soft_reset;
    load(5000, -300, 1000, 200);
    clk_en = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick;
    end
    n_cmp++;
    if (step_cnt !== 16'd1 || busy !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL abort_pre: got step=%0d busy=%b, required 1/1", step_cnt, busy);
    end
    rst_i  = 1'b1;
    x_init = 18'sd7000;
    v_init = 18'sd42;
    tick;
    n_cmp++;
    if (x_out !== 18'sd7000 || v_out !== 18'sd42 || step_cnt !== 16'd0 ||
        busy !== 1'b0 || sample_valid !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL abort_state: got x=%0d v=%0d step=%0d busy=%b sv=%b, required 7000/42/0/0/0",
               x_out, v_out, step_cnt, busy, sample_valid);
    end
    x_init = -18'sd1234;
    tick;
    n_cmp++;
    if (x_out !== -18'sd1234 || busy !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL abort_track: got x=%0d busy=%b, required -1234/0", x_out, busy);
    end
    rst_i  = 1'b0;
    clk_en = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (sample_valid !== 1'b0) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL abort_quiet: got sv=%b, required 0", sample_valid);
      end
    end
    // An asynchronous reset in the middle of a step returns everything to zero without a clock edge.
    clk_en = 1'b1;
    tick;
    tick;
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if (x_out !== 18'sd0 || v_out !== 18'sd0 || busy !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL async_mid: got x=%0d v=%0d busy=%b, required 0/0/0", x_out, v_out, busy);
    end
    clk_en = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  task automatic test_saturation;
    longint ex;
    longint ev;
    longint ex6;
    longint ev6;
    longint x_req;
    int     seen;
    load(131071, 131071, 0, 0);
    model_step(131071, 131071, 0, 0, 0, ex, ev);
    model_step(131071, 131071, 0, 0, 6, ex6, ev6);
`ifdef ODE_SAT_EN
    x_req = 131071;
`else
    x_req = -2;
`endif
    clk_en = 1'b1;
    tick;
    clk_en = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick;
      if (sample2_valid === 1'b1) seen++;
    end
    n_cmp++;
    if (seen !== 1 || x2_out !== 18'(ex) || v2_out !== 18'(ev)) begin
      n_bad++;
      $display("[TB] FAIL sat_model: got samples=%0d x=%0d v=%0d, required 1/%0d/%0d",
               seen, x2_out, v2_out, ex, ev);
    end
    n_cmp++;
    if (x2_out !== 18'(x_req)) begin
      n_bad++;
      $display("[TB] FAIL sat_const: got x=%0d, required %0d", x2_out, x_req);
    end
    n_cmp++;
    if (x_out !== 18'(ex6) || v_out !== 18'(ev6)) begin
      n_bad++;
      $display("[TB] FAIL sat_dt6: got x=%0d v=%0d, required %0d/%0d", x_out, v_out, ex6, ev6);
    end
  endtask

  task automatic test_counter_wrap;
    exp_t   e;
    longint mx;
    longint mv;
    int     seen;
    int     last;
    load(0, 1, 0, 0);
    mx = 0;
    mv = 1;
    for (int i = 1; i <= 17; i++) begin
      model_step(mx, mv, 0, 0, 0, mx, mv);
      exp_q.push_back('{mx, mv, i % 16});
    end
    seen = 0;
    last = -1;
    clk_en = 1'b1;
    for (int c = 1; c <= 95; c++) begin
      tick;
      if (c == 85) clk_en = 1'b0;
      if (sample2_valid === 1'b1) begin
        seen++;
        if (last >= 0 && c - last != 5) begin
          n_cmp++;
          n_bad++;
          $display("[TB] FAIL wrap_period: got %0d cycles, required 5", c - last);
        end
        last = c;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("[TB] FAIL wrap_extra: got unexpected sample, required none");
        end else begin
          e = exp_q.pop_front();
          if (x2_out !== 18'(e.x) || step2_cnt !== 4'(e.step)) begin
            n_bad++;
            $display("[TB] FAIL wrap_sample: got x=%0d step=%0d, required %0d/%0d",
                     x2_out, step2_cnt, e.x, e.step);
          end
        end
      end
    end
    n_cmp++;
    if (seen !== 17 || step2_cnt !== 4'd1 || x2_out !== 18'sd17) begin
      n_bad++;
      $display("[TB] FAIL wrap_total: got samples=%0d step=%0d x=%0d, required 17/1/17",
               seen, step2_cnt, x2_out);
    end
    exp_q.delete();
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst_n  = 1'b1;
    rst_i  = 1'b0;
    clk_en = 1'b0;
    x_init = '0;
    v_init = '0;
    k_coef = '0;
    b_coef = '0;
    test_reset;
    test_single_step;
    test_free_run;
    test_back_to_back;
    test_soft_reset;
    test_saturation;
    test_counter_wrap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion by 200000 ns, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
